// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding, default sizes and counter-width helper for rst_seq_ctrl
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_LOCKWAIT = 2'd1,
    ST_SEQ      = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam int DEF_NCH       = 4;
  localparam int DEF_GAPW      = 8;
  localparam int DEF_LOCK_CNT  = 8;
  localparam int DEF_PULSE_LEN = 16;
  localparam int DEF_WDT_CNT   = 65535;

  // Bits needed to hold every value 0..maxval (never less than one bit).
  function automatic int cntw(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/rst_seq_lockqual.sv
// rtl/rst_seq_lockqual.sv - counts consecutive lock cycles and flags a qualified lock
module rst_seq_lockqual
  import rst_seq_pkg::*;
#(
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_lock,
  output logic o_qlock
);

  localparam int QW = cntw(LOCK_CNT - 1);

  logic [QW-1:0] r_cnt;
  logic          w_last;

  assign w_last  = (r_cnt == QW'(LOCK_CNT - 1));
  assign o_qlock = i_active && i_lock && w_last;

  // Run of lock=1 cycles; any gap, qualification or leaving the wait state restarts it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || !i_lock || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged reset-mask release with per-channel software pulses; RST_SEQ_WDT_EN adds a lock watchdog
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int GAPW      = DEF_GAPW,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int WDT_CNT   = DEF_WDT_CNT
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            enable,
  input  logic            lock,
  input  logic [GAPW-1:0] gap,
  input  logic            scanmode,
  input  logic [NCH-1:0]  swrst_req,
  output logic [NCH-1:0]  rstmsk,
  output logic [NCH-1:0]  swrst_ack,
  output logic            done,
  output logic            wdt_to
);

  localparam int IDXW = cntw(NCH);
  localparam int CHW  = cntw(NCH - 1);
  localparam int PW   = cntw(PULSE_LEN - 1);

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [GAPW-1:0] r_cnt, w_cnt_nxt;
  logic [GAPW-1:0] r_gap, w_gap_nxt;
  logic [NCH-1:0]  r_rstmsk, w_rstmsk_nxt;
  logic [NCH-1:0]  r_ack, w_ack_nxt;
  logic            r_pact, w_pact_nxt;
  logic [CHW-1:0]  r_pch, w_pch_nxt;
  logic [PW-1:0]   r_pcnt, w_pcnt_nxt;
  logic [CHW-1:0]  w_req_ch;
  logic            w_req_hit;
  logic            w_qlock;
  logic            w_in_lw;
  logic            w_lock_lost;

  assign w_in_lw     = (r_state == ST_LOCKWAIT);
  assign w_lock_lost = !lock && ((r_state == ST_SEQ) || (r_state == ST_RUN));

  rst_seq_lockqual #(
    .LOCK_CNT (LOCK_CNT)
  ) u_lockqual (
    .i_clk    (clk),
    .i_rst_n  (rst_),
    .i_active (w_in_lw),
    .i_lock   (lock),
    .o_qlock  (w_qlock)
  );

  // Lowest-index pending software request wins.
  always_comb begin
    w_req_hit = 1'b0;
    w_req_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (swrst_req[i]) begin
        w_req_hit = 1'b1;
        w_req_ch  = CHW'(i);
      end
    end
  end

  // Next-state and next-output decision; disable beats lock loss, lock loss beats everything else.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap;
    w_rstmsk_nxt = r_rstmsk;
    w_ack_nxt    = '0;
    w_pact_nxt   = r_pact;
    w_pch_nxt    = r_pch;
    w_pcnt_nxt   = r_pcnt;
    if (!enable || w_lock_lost) begin
      w_state_nxt  = enable ? ST_LOCKWAIT : ST_OFF;
      w_idx_nxt    = '0;
      w_cnt_nxt    = '0;
      w_gap_nxt    = '0;
      w_rstmsk_nxt = '0;
      w_pact_nxt   = 1'b0;
      w_pch_nxt    = '0;
      w_pcnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_LOCKWAIT;
        end
        ST_LOCKWAIT: begin
          if (w_qlock) begin
            w_state_nxt = ST_SEQ;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_gap_nxt   = gap;
          end
        end
        ST_SEQ: begin
          if (r_idx == IDXW'(NCH)) begin
            w_state_nxt = ST_RUN;
          end else if (r_cnt == r_gap) begin
            w_rstmsk_nxt = r_rstmsk | (NCH'(1) << r_idx);
            w_idx_nxt    = r_idx + 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (r_pact) begin
            if (r_pcnt == PW'(PULSE_LEN - 1)) begin
              w_pact_nxt   = 1'b0;
              w_pcnt_nxt   = '0;
              w_rstmsk_nxt = r_rstmsk | (NCH'(1) << r_pch);
              w_ack_nxt    = NCH'(1) << r_pch;
            end else begin
              w_pcnt_nxt = r_pcnt + 1'b1;
            end
          end else if (w_req_hit && (r_ack == '0)) begin
            // The acked requester gets one cycle to drop its request before a new pulse can start.
            w_pact_nxt   = 1'b1;
            w_pch_nxt    = w_req_ch;
            w_pcnt_nxt   = '0;
            w_rstmsk_nxt = r_rstmsk & ~(NCH'(1) << w_req_ch);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state  <= ST_OFF;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_rstmsk <= '0;
      r_ack    <= '0;
      r_pact   <= 1'b0;
      r_pch    <= '0;
      r_pcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_rstmsk <= w_rstmsk_nxt;
      r_ack    <= w_ack_nxt;
      r_pact   <= w_pact_nxt;
      r_pch    <= w_pch_nxt;
      r_pcnt   <= w_pcnt_nxt;
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam int WW = cntw(WDT_CNT - 1);

  logic [WW-1:0] r_wdt;
  logic          r_wdt_to;

  // Time spent waiting for lock; saturates and latches the timeout until disable or reset.
  always_ff @(posedge clk) begin
    if (!rst_ || !enable) begin
      r_wdt    <= '0;
      r_wdt_to <= 1'b0;
    end else if (w_in_lw) begin
      if (r_wdt == WW'(WDT_CNT - 1)) begin
        r_wdt_to <= 1'b1;
      end else begin
        r_wdt <= r_wdt + 1'b1;
      end
    end else begin
      r_wdt <= '0;
    end
  end

  assign wdt_to = r_wdt_to;
`else
  assign wdt_to = 1'b0;
`endif

  assign rstmsk    = scanmode ? {NCH{1'b1}} : r_rstmsk;
  assign swrst_ack = r_ack;
  assign done      = (r_state == ST_RUN);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed scenarios plus randomized run against a timeline model of rst_seq_ctrl
module tb_rst_seq_ctrl;

  localparam int NCH       = 4;
  localparam int GAPW      = 8;
  localparam int LOCK_CNT  = 8;
  localparam int PULSE_LEN = 16;
  localparam int WDT_CNT   = 100;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_;
  logic            enable;
  logic            lock;
  logic [GAPW-1:0] gap;
  logic            scanmode;
  logic [NCH-1:0]  swrst_req;
  logic [NCH-1:0]  rstmsk;
  logic [NCH-1:0]  swrst_ack;
  logic            done;
  logic            wdt_to;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: 0 off, 1 waiting for lock, 2 sequencing, 3 running.
  int m_mode = 0;
  int m_qual = 0;
  int m_t    = 0;
  int m_gap  = 0;
  int m_pch  = -1;
  int m_prem = 0;
  int m_ack  = -1;
  int m_wdt  = 0;
  bit m_wto  = 1'b0;

  rst_seq_ctrl #(
    .NCH       (NCH),
    .GAPW      (GAPW),
    .LOCK_CNT  (LOCK_CNT),
    .PULSE_LEN (PULSE_LEN),
    .WDT_CNT   (WDT_CNT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .enable    (enable),
    .lock      (lock),
    .gap       (gap),
    .scanmode  (scanmode),
    .swrst_req (swrst_req),
    .rstmsk    (rstmsk),
    .swrst_ack (swrst_ack),
    .done      (done),
    .wdt_to    (wdt_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_mask();
    logic [NCH-1:0] m;
    int n;
    m = '0;
    if (scanmode) return '1;
    if (m_mode == 2) begin
      n = m_t / (m_gap + 1);
      if (n > NCH) n = NCH;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
    end else if (m_mode == 3) begin
      m = '1;
      if (m_pch >= 0) m[m_pch] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [NCH-1:0] exp_ack();
    logic [NCH-1:0] a;
    a = '0;
    if (m_ack >= 0) a[m_ack] = 1'b1;
    return a;
  endfunction

  always @(posedge clk) begin : model_upd
    int old_ack;
    old_ack = m_ack;
    m_ack   = -1;
    if (!rst_) begin
      m_mode = 0; m_qual = 0; m_t = 0; m_pch = -1; m_wdt = 0; m_wto = 1'b0;
    end else if (!enable) begin
      m_mode = 0; m_qual = 0; m_pch = -1; m_wdt = 0; m_wto = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          m_mode = 1; m_qual = 0;
        end
        1: begin
          m_wdt++;
          if (WDT_EN && m_wdt == WDT_CNT) m_wto = 1'b1;
          if (lock) begin
            m_qual++;
            if (m_qual == LOCK_CNT) begin
              m_mode = 2; m_t = 0; m_gap = int'(gap); m_qual = 0;
            end
          end else begin
            m_qual = 0;
          end
        end
        2: begin
          if (!lock) begin
            m_mode = 1; m_qual = 0;
          end else begin
            m_t++;
            if (m_t == NCH * (m_gap + 1) + 1) m_mode = 3;
          end
        end
        default: begin
          if (!lock) begin
            m_mode = 1; m_qual = 0; m_pch = -1;
          end else if (m_pch >= 0) begin
            m_prem--;
            if (m_prem == 0) begin
              m_ack = m_pch; m_pch = -1;
            end
          end else if (old_ack < 0 && swrst_req != '0) begin
            for (int i = 0; i < NCH; i++) begin
              if (swrst_req[i]) begin
                m_pch = i;
                break;
              end
            end
            m_prem = PULSE_LEN;
          end
        end
      endcase
      if (m_mode != 1) m_wdt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rstmsk", int'(rstmsk), int'(exp_mask()));
      check("model_ack", int'(swrst_ack), int'(exp_ack()));
      check("model_done", int'(done), (m_mode == 3) ? 1 : 0);
      check("model_wdt_to", int'(wdt_to), int'(m_wto));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  initial begin
    int low1, low2, a1, a2, bad, edges;
    rst_ = 1'b0; enable = 1'b0; lock = 1'b0; gap = '0; scanmode = 1'b0; swrst_req = '0;
    cyc();
    chk_on = 1'b1;
    cyc();
    check("reset_rstmsk", int'(rstmsk), 0);
    check("reset_ack", int'(swrst_ack), 0);
    check("reset_done", int'(done), 0);
    check("reset_wdt_to", int'(wdt_to), 0);

    // Staged release with gap=3.
    rst_ = 1'b1; enable = 1'b1; lock = 1'b1; gap = 8'd3;
    repeat (9) cyc();
    check("seq_entry_mask", int'(rstmsk), 0);
    for (int k = 0; k < NCH; k++) begin
      repeat (4) cyc();
      check("seq_stage_mask", int'(rstmsk), (1 << (k + 1)) - 1);
    end
    check("done_before_run", int'(done), 0);
    cyc();
    check("done_in_run", int'(done), 1);

    // Software pulses on channels 1 then 2.
    swrst_req = 4'b0110;
    low1 = 0; low2 = 0; a1 = 0; a2 = 0; bad = 0;
    for (int n = 0; n < 80; n++) begin
      cyc();
      if (!rstmsk[1]) low1++;
      if (!rstmsk[2]) low2++;
      if (!rstmsk[0] || !rstmsk[3] || !done) bad++;
      if (swrst_ack[1]) begin a1++; swrst_req[1] = 1'b0; end
      if (swrst_ack[2]) begin a2++; swrst_req[2] = 1'b0; end
    end
    check("ch1_low_cycles", low1, 16);
    check("ch2_low_cycles", low2, 16);
    check("ch1_ack_count", a1, 1);
    check("ch2_ack_count", a2, 1);
    check("others_undisturbed", bad, 0);

    // Lock loss in RUN and full re-sequence.
    lock = 1'b0;
    cyc();
    check("lockloss_mask", int'(rstmsk), 0);
    check("lockloss_done", int'(done), 0);
    lock = 1'b1;
    repeat (8) cyc();
    check("requal_mask", int'(rstmsk), 0);
    repeat (16) cyc();
    check("reseq_mask", int'(rstmsk), 15);
    cyc();
    check("reseq_done", int'(done), 1);

    // One-cycle lock glitch during qualification delays SEQ entry by 6.
    enable = 1'b0;
    cyc();
    check("disable_mask", int'(rstmsk), 0);
    gap = 8'd0; enable = 1'b1; lock = 1'b1;
    cyc();
    repeat (5) cyc();
    lock = 1'b0;
    cyc();
    lock = 1'b1;
    edges = 7;
    for (int n = 0; n < 40; n++) begin
      cyc();
      edges++;
      if (rstmsk[0]) break;
    end
    check("lock_glitch_first_release", edges, 16);

    // Scan bypass while off, then reset mid-sequence.
    enable = 1'b0;
    cyc();
    scanmode = 1'b1;
    cyc();
    check("scan_off_mask", int'(rstmsk), 15);
    check("scan_off_done", int'(done), 0);
    scanmode = 1'b0; enable = 1'b1; lock = 1'b1; gap = 8'd2;
    repeat (9) cyc();
    repeat (4) cyc();
    check("midseq_mask", int'(rstmsk), 1);
    rst_ = 1'b0;
    cyc();
    check("midseq_reset_mask", int'(rstmsk), 0);
    rst_ = 1'b1;
    repeat (9) cyc();
    check("after_reset_no_partial", int'(rstmsk), 0);
    repeat (3) cyc();
    check("after_reset_first", int'(rstmsk), 1);

    // Lock stuck low: watchdog.
    rst_ = 1'b0;
    cyc();
    rst_ = 1'b1; enable = 1'b1; lock = 1'b0;
    cyc();
    repeat (99) cyc();
    check("wdt_before_limit", int'(wdt_to), 0);
    cyc();
    check("wdt_at_limit", int'(wdt_to), WDT_EN ? 1 : 0);

    // Randomized operation.
    swrst_req = '0;
    for (int n = 0; n < 4000; n++) begin
      rst_     = ($urandom_range(0, 999) != 0);
      enable   = ($urandom_range(0, 299) != 0);
      lock     = ($urandom_range(0, 149) != 0);
      scanmode = ($urandom_range(0, 19) == 0);
      gap      = GAPW'($urandom_range(0, 4));
      for (int i = 0; i < NCH; i++) begin
        if (swrst_ack[i] && $urandom_range(0, 3) != 0) swrst_req[i] = 1'b0;
        else if (!swrst_req[i] && $urandom_range(0, 39) == 0) swrst_req[i] = 1'b1;
      end
      cyc();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter: NCH, 4, number of sequenced reset-mask channels.
REQ-002 Parameter: GAPW, 8, width of the inter-channel gap value.
REQ-003 Parameter: LOCK_CNT, 8, consecutive lock=1 cycles required to qualify lock.
REQ-004 Parameter: PULSE_LEN, 16, software-reset low-pulse length in cycles.
REQ-005 Parameter: WDT_CNT, 65535, lock watchdog limit in cycles.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: rst_  input  1  reset, synchronous and active-low.
REQ-008 Port: enable  input  1  sequencer enable.
REQ-009 Port: lock  input  1  PLL/clock-source lock, already synchronous to clk.
REQ-010 Port: gap  input  GAPW  cycles between channel releases, minus one.
REQ-011 Port: scanmode  input  1  scan bypass.
REQ-012 Port: swrst_req  input  NCH  per-channel software reset request, level.
REQ-013 Port: rstmsk  output  NCH  reset-mask outputs, one per downstream reset synchronizer; 1 = released.
REQ-014 Port: swrst_ack  output  NCH  one-cycle acknowledge per channel.
REQ-015 Port: done  output  1  all channels released by the global sequence.
REQ-016 Port: wdt_to  output  1  lock watchdog timeout, sticky.

Function
REQ-017 States: OFF, LOCKWAIT, SEQ, RUN.
REQ-018 OFF: rstmsk=0, done=0; go to LOCKWAIT when enable=1.
REQ-019 LOCKWAIT: qualification counter increments while lock=1 and clears on lock=0; at count LOCK_CNT-1 with lock=1, go to SEQ with idx=0 and cnt=0.
REQ-020 SEQ: gap is sampled on SEQ entry; cnt runs 0..gap; at cnt==gap, set rstmsk[idx], increment idx, clear cnt.
REQ-021 SEQ timing: rstmsk[k] rises (k+1)*(gap+1) cycles after SEQ entry; gap=0 releases one channel per cycle.
REQ-022 SEQ exit: go to RUN on the cycle after rstmsk[NCH-1] sets; done=1 while in RUN.
REQ-023 Released channels stay released; channels are never released out of index order.
REQ-024 lock=0 in SEQ or RUN: next cycle rstmsk=0, done=0, abort any pulse without ack, go to LOCKWAIT.
REQ-025 enable=0 in any state: next cycle go to OFF with all outputs cleared; this takes priority over lock loss.
REQ-026 RUN accepts swrst_req only when no pulse is active; the lowest set index wins.
REQ-027 Accepted channel i: rstmsk[i]=0 for exactly PULSE_LEN cycles, then rstmsk[i]=1 and swrst_ack[i]=1 for one cycle in the same cycle.
REQ-028 Pending requests wait until the current pulse ends; the requester holds swrst_req until it sees the ack, and a request still high after its ack restarts a pulse.
REQ-029 done stays 1 during software pulses; other channels are unaffected.
REQ-030 scanmode=1 forces rstmsk to all ones combinationally; internal state continues unchanged.

Reset
REQ-031 rst_=0 at a clk edge: state=OFF, rstmsk=0, swrst_ack=0, done=0, wdt_to=0, all counters and idx 0.
REQ-032 Reset asserted mid-SEQ or mid-pulse takes effect at the next edge with no partial release retained.

Configuration
REQ-033 Macro RST_SEQ_WDT_EN defined: a watchdog counter runs in LOCKWAIT and clears on leaving LOCKWAIT.
REQ-034 With RST_SEQ_WDT_EN, reaching WDT_CNT cycles in LOCKWAIT sets wdt_to=1; wdt_to clears only on reset or enable=0; sequencing is otherwise unaffected.
REQ-035 Macro RST_SEQ_WDT_EN undefined: no watchdog logic; the wdt_to port remains and is tied 0.

Structure
REQ-036 Package rst_seq_pkg holds the state encoding, default NCH/GAPW/LOCK_CNT/PULSE_LEN constants and counter widths.
REQ-037 Sub-module rst_seq_lockqual holds the lock qualification counter and its qualified-lock output.
REQ-038 rstmsk[k] drives the rstmsk input of the k-th per-domain reset synchronizer.

Verification
REQ-039 Scenario: LOCK_CNT=8, gap=3, enable=1, lock=1 -> rstmsk=0001/0011/0111/1111 at 4/8/12/16 cycles after SEQ entry; done=1 one cycle later.
REQ-040 Scenario: lock low for 1 cycle at qualification count 5 -> counter restarts; SEQ entry delayed by 6 cycles.
REQ-041 Scenario: lock drops in RUN -> rstmsk=0000 and done=0 next cycle; full re-sequence after requalification.
REQ-042 Scenario: swrst_req=0110 in RUN -> ch1 low 16 cycles then ack[1]; ch2 low 16 cycles then ack[2]; ch0 and ch3 stay 1.
REQ-043 Scenario: scanmode=1 while in OFF -> rstmsk=1111; rst_=0 during SEQ -> next edge OFF with all counters 0.
REQ-044 Scenario: WDT_CNT=100, lock stuck 0 -> wdt_to=1 at cycle 100 in LOCKWAIT with RST_SEQ_WDT_EN; wdt_to stays 0 without it.
